// File: rtl/ex_mem_skid.sv
// EX->MEM pipeline register with a two-entry skid buffer and flush; optional overflow trap under `OVF_TRAP_EN`.
// Latency: 1 cycle from an accepted input to out_valid when the stage is empty; entries leave in strict FIFO order.
// Backpressure: in_ready is a flop (low only while both entries are occupied), so out_ready never reaches in_ready combinationally.
module ex_mem_skid #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sum,
  input  logic              in_zout,
  input  logic              in_nout,
  input  logic              in_ovf,
  input  logic              in_ovf_chk,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_regwrite,
  input  logic              in_memread,
  input  logic              in_memwrite,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [DATA_W-1:0] in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_zout,
  output logic              out_nout,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_regwrite,
  output logic              out_memread,
  output logic              out_memwrite,
  output logic [DATA_W-1:0] out_wdata,
  output logic [DATA_W-1:0] out_pc,
  output logic              exc_ovf,
  output logic [DATA_W-1:0] exc_pc
);

  typedef struct packed {
    logic [DATA_W-1:0] sum;
    logic              zout;
    logic              nout;
    logic [REG_W-1:0]  rd;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] pc;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;

  entry_t in_entry;
  logic   in_xfer;
  logic   out_xfer;
  logic   trap;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;

`ifdef OVF_TRAP_EN
  assign trap = in_ovf & in_ovf_chk;
`else
  // Overflow inputs have no effect when the trap is compiled out.
  logic unused_ovf;
  assign unused_ovf = in_ovf ^ in_ovf_chk;
  assign trap       = 1'b0;
`endif

  // Pack the incoming word; a trapping instruction has its side effects stripped.
  always_comb begin
    in_entry.sum      = in_sum;
    in_entry.zout     = in_zout;
    in_entry.nout     = in_nout;
    in_entry.rd       = in_rd;
    in_entry.regwrite = in_regwrite & ~trap;
    in_entry.memread  = in_memread & ~trap;
    in_entry.memwrite = in_memwrite & ~trap;
    in_entry.wdata    = in_wdata;
    in_entry.pc       = in_pc;
  end

  // Next state, buffer moves and registered handshake outputs.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Buffer contents are left in place so out_* keep their last value.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_d  = in_entry;
            state_d = FULL;
          end
        end
        FULL: begin
          if (in_xfer && out_xfer) begin
            main_d = in_entry;
          end else if (in_xfer) begin
            skid_d  = in_entry;
            state_d = SKID;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        SKID: begin
          if (out_xfer) begin
            main_d  = skid_q;
            state_d = FULL;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d  = (state_d != SKID);
    out_valid_d = (state_d != EMPTY);
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef OVF_TRAP_EN
  logic              exc_ovf_q;
  logic [DATA_W-1:0] exc_pc_q;

  // One-cycle trap pulse for each accepted overflowing word; PC held until the next trap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      exc_ovf_q <= 1'b0;
      exc_pc_q  <= '0;
    end else begin
      exc_ovf_q <= in_xfer & ~flush & trap;
      if (in_xfer && !flush && trap) begin
        exc_pc_q <= in_pc;
      end
    end
  end

  assign exc_ovf = exc_ovf_q;
  assign exc_pc  = exc_pc_q;
`else
  assign exc_ovf = 1'b0;
  assign exc_pc  = '0;
`endif

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_sum      = main_q.sum;
  assign out_zout     = main_q.zout;
  assign out_nout     = main_q.nout;
  assign out_rd       = main_q.rd;
  assign out_regwrite = main_q.regwrite;
  assign out_memread  = main_q.memread;
  assign out_memwrite = main_q.memwrite;
  assign out_wdata    = main_q.wdata;
  assign out_pc       = main_q.pc;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Bench for ex_mem_skid: directed reset/stream/backpressure/flush/trap cases plus a random run.
// Expected words are queued when the bench sees an input transfer and compared at each output transfer.
// Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge.
module tb_ex_mem_skid;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int PW     = 3 * DATA_W + REG_W + 5;
`ifdef OVF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n, flush, in_valid, in_ready;
  logic [DATA_W-1:0] in_sum, in_wdata, in_pc;
  logic              in_zout, in_nout, in_ovf, in_ovf_chk;
  logic [REG_W-1:0]  in_rd;
  logic              in_regwrite, in_memread, in_memwrite;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_sum, out_wdata, out_pc;
  logic              out_zout, out_nout;
  logic [REG_W-1:0]  out_rd;
  logic              out_regwrite, out_memread, out_memwrite;
  logic              exc_ovf;
  logic [DATA_W-1:0] exc_pc;

  ex_mem_skid #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_zout(in_zout), .in_nout(in_nout),
    .in_ovf(in_ovf), .in_ovf_chk(in_ovf_chk), .in_rd(in_rd),
    .in_regwrite(in_regwrite), .in_memread(in_memread), .in_memwrite(in_memwrite),
    .in_wdata(in_wdata), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_zout(out_zout), .out_nout(out_nout), .out_rd(out_rd),
    .out_regwrite(out_regwrite), .out_memread(out_memread), .out_memwrite(out_memwrite),
    .out_wdata(out_wdata), .out_pc(out_pc),
    .exc_ovf(exc_ovf), .exc_pc(exc_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  logic [PW-1:0] out_vec;
  assign out_vec = {out_sum, out_zout, out_nout, out_rd, out_regwrite, out_memread,
                    out_memwrite, out_wdata, out_pc};

  // Scoreboard state, owned by the monitor process.
  logic [PW-1:0]     sb[$];
  logic [PW-1:0]     held_vec;
  logic [PW-1:0]     exp_vec;
  logic              armed = 1'b0;
  logic              prev_stall = 1'b0;
  logic              exp_exc = 1'b0;
  logic [DATA_W-1:0] exp_pc = '0;
  logic              t_rw, t_mr, t_mw;

  // Falling-edge monitor: checks the state left by the last edge, then predicts the next edge.
  always @(negedge clk) begin
    if (armed) begin
      check("in_ready", in_ready, sb.size() < 2);
      check("out_valid", out_valid, sb.size() > 0);
      check("exc_ovf", exc_ovf, exp_exc);
      check("exc_pc", exc_pc, exp_pc);
      if (prev_stall) check("stall_hold", out_vec, held_vec);
    end
    prev_stall = 1'b0;
    if (!reset_n) begin
      sb.delete();
      exp_exc = 1'b0;
      exp_pc  = '0;
      armed   = 1'b1;
    end else if (armed) begin
      exp_exc = 1'b0;
      if (flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready && sb.size() > 0) check("out_data", out_vec, sb.pop_front());
        if (out_valid && !out_ready) begin
          prev_stall = 1'b1;
          held_vec   = out_vec;
        end
        if (in_valid && in_ready) begin
          t_rw = in_regwrite;
          t_mr = in_memread;
          t_mw = in_memwrite;
          if (TRAP && in_ovf && in_ovf_chk) begin
            t_rw    = 1'b0;
            t_mr    = 1'b0;
            t_mw    = 1'b0;
            exp_exc = 1'b1;
            exp_pc  = in_pc;
          end
          exp_vec = {in_sum, in_zout, in_nout, in_rd, t_rw, t_mr, t_mw, in_wdata, in_pc};
          sb.push_back(exp_vec);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input logic [DATA_W-1:0] s, input logic [DATA_W-1:0] pc);
    in_sum      = s;
    in_pc       = pc;
    in_wdata    = ~s;
    in_rd       = s[REG_W-1:0];
    in_zout     = (s == 0);
    in_nout     = s[DATA_W-1];
    in_regwrite = 1'b1;
    in_memread  = s[0];
    in_memwrite = s[1];
    in_ovf      = 1'b0;
    in_ovf_chk  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    set_word(32'h55, 32'h100);

    // 1: reset held three cycles with a valid word presented.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_sum", out_sum, 0);
      check("rst_exc_ovf", exc_ovf, 0);
    end
    reset_n = 1'b1; in_valid = 1'b0;
    tick();

    // 2: back-to-back stream with the sink always ready.
    in_valid = 1'b1;
    set_word(32'd1, 32'h200);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("stream_sum", out_sum, i);
      check("stream_valid", out_valid, 1);
      check("stream_rdy", in_ready, 1);
      if (i < 8) set_word(i + 1, 32'h200 + 4 * i);
      else in_valid = 1'b0;
    end
    tick();
    check("stream_drained", out_valid, 0);

    // 3: backpressure fills main then skid; the third word must wait.
    out_ready = 1'b0; in_valid = 1'b1;
    set_word(32'hA, 32'h300);
    tick();
    check("bp_a_out", out_sum, 32'hA);
    check("bp_a_rdy", in_ready, 1);
    set_word(32'hB, 32'h304);
    tick();
    check("bp_b_rdy", in_ready, 0);
    check("bp_b_out", out_sum, 32'hA);
    set_word(32'hC, 32'h308);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("bp_c_rdy", in_ready, 0);
      check("bp_c_out", out_sum, 32'hA);
    end
    out_ready = 1'b1;
    tick();
    check("bp_rel_b", out_sum, 32'hB);
    check("bp_rel_rdy", in_ready, 1);
    tick();
    check("bp_rel_c", out_sum, 32'hC);
    in_valid = 1'b0;
    tick();
    check("bp_drained", out_valid, 0);

    // 4: flush while both entries are full and a new word is offered.
    out_ready = 1'b0; in_valid = 1'b1;
    set_word(32'hE, 32'h400);
    tick();
    set_word(32'hF, 32'h404);
    tick();
    check("fl_skid_rdy", in_ready, 0);
    set_word(32'hD, 32'h408);
    flush = 1'b1;
    tick();
    check("fl_out_valid", out_valid, 0);
    check("fl_in_ready", in_ready, 1);
    check("fl_hold_sum", out_sum, 32'hE);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl_stays_empty", out_valid, 0);
    end

    // 5: overflowing ADD with and without the trap qualifier.
    in_valid = 1'b1;
    set_word(32'h8000_0000, 32'h40);
    in_ovf = 1'b1; in_ovf_chk = 1'b1;
    tick();
    check("ovf_regwrite", out_regwrite, !TRAP);
    check("ovf_exc", exc_ovf, TRAP);
    check("ovf_pc", exc_pc, TRAP ? 32'h40 : 32'h0);
    in_valid = 1'b0;
    tick();
    check("ovf_pulse_end", exc_ovf, 0);
    check("ovf_pc_held", exc_pc, TRAP ? 32'h40 : 32'h0);
    in_valid = 1'b1;
    set_word(32'h8000_0000, 32'h44);
    in_ovf = 1'b1; in_ovf_chk = 1'b0;
    tick();
    check("nochk_regwrite", out_regwrite, 1);
    check("nochk_exc", exc_ovf, 0);
    in_valid = 1'b0;
    tick();

    // 6: random valid/ready/flush traffic against the scoreboard.
    for (int i = 0; i < 10000; i++) begin
      in_valid    = ($urandom_range(0, 9) < 7);
      out_ready   = ($urandom_range(0, 9) < 6);
      flush       = ($urandom_range(0, 31) == 0);
      in_sum      = $urandom;
      in_wdata    = $urandom;
      in_pc       = $urandom;
      in_rd       = REG_W'($urandom);
      in_zout     = $urandom_range(0, 1);
      in_nout     = $urandom_range(0, 1);
      in_regwrite = $urandom_range(0, 1);
      in_memread  = $urandom_range(0, 1);
      in_memwrite = $urandom_range(0, 1);
      in_ovf      = ($urandom_range(0, 3) == 0);
      in_ovf_chk  = $urandom_range(0, 1);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("drain_valid", out_valid, 0);
    check("drain_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
